buffer_a_in: RTL
================

Name: buffer_a_in

Overview:
- Input-side row buffer for the systolic MMU; the counterpart of the output-side row buffer.
- Accepts a matrix tile one scalar element per cycle, column-major (row index inner, column index outer), and stores each element in lane `col` of word `row`.
- On command, replays the stored tile to the MMU as full-width row vectors, one row per cycle, last row first.

Parameters:
VAR_SIZE, 8, bit width of one matrix element (signed)
MMU_SIZE, 4, lanes per row word (max columns)
DEPTH, 4, number of row words stored (max rows); address width 8

Ports:
clk  input  1  clock
rst  input  1  reset (see Behaviour)
A  input  VAR_SIZE  signed scalar element, consumed in LOAD when stop=0
stop  input  1  LOAD: no element this cycle (hold pointers)
cmd  input  2  00 NONE, 01 LOAD, 10 SEND, 11 CLEAR
dim_x_in  input  8  row count of tile, sampled on LOAD command
dim_y_in  input  8  column count of tile, sampled on LOAD command
B1  output  VAR_SIZE*MMU_SIZE  row vector to MMU, lane k at bits [k*VAR_SIZE +: VAR_SIZE]
out_valid  output  1  B1 holds a valid row this cycle
busy  output  1  state != IDLE
dim_x  output  8  stored tile rows
dim_y  output  8  stored tile columns

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset: state IDLE, pointers 0, dim_x = dim_y = 0, B1 = 0, out_valid = 0, busy = 0.
- Reset does not clear the storage array. Reset asserted mid-LOAD or mid-SEND aborts immediately with the values above.
- States: IDLE, LOAD, SEND, CLEAR. cmd is sampled only in IDLE, except the abort case under LOAD.
- Dimension clamp on capture:
  - dx = min(dim_x_in, DEPTH), dy = min(dim_y_in, MMU_SIZE).
  - LOAD with dx = 0 or dy = 0 is ignored: stay IDLE, dims unchanged.
- IDLE:
  - cmd LOAD: dim_x <= dx, dim_y <= dy, row_ptr <= 0, col_ptr <= 0, go to LOAD.
  - cmd SEND with dim_x = 0: ignored.
  - cmd SEND otherwise: row_ptr <= dim_x-1, go to SEND.
  - cmd CLEAR: go to CLEAR.
- LOAD:
  - Each cycle with stop = 0: mem[row_ptr] lane col_ptr <= A; other lanes unchanged.
  - Pointer advance: if row_ptr = dim_x-1 then row_ptr <= 0 and col_ptr++, else row_ptr++.
  - The write of (dim_x-1, dim_y-1) ends LOAD; next state IDLE.
  - stop = 1: no write, pointers held.
  - stop = 1 and cmd = CLEAR: go to CLEAR (abort); the partial tile is discarded by the clear.
  - Total accepted elements = dim_x*dim_y.
- SEND:
  - One row per cycle, not stallable.
  - At the edge ending a SEND cycle: B1 <= mem[row_ptr] with lanes >= dim_y forced to 0; out_valid <= 1; row_ptr--.
  - The edge that emits row 0 returns to IDLE.
  - Latency: SEND command in IDLE at edge t; rows dim_x-1..0 are valid on B1 in cycles t+2..t+1+dim_x.
  - out_valid = 0 in every other cycle. B1 holds its last value when out_valid = 0.
  - Storage is not modified by SEND; repeated SENDs replay the same tile.
- CLEAR (one cycle): all storage words <= 0, dim_x <= 0, dim_y <= 0, pointers 0, next state IDLE.
- busy is combinational from state.
- Element arithmetic: none; data are passed bit-exact, signed.

Test Plan:
- Reset: assert rst 2 cycles with traffic on cmd -> B1=0, out_valid=0, busy=0, dim_x=dim_y=0.
- Load/send: LOAD dim 2x3 with A=1..6 streamed (order r0c0, r1c0, r0c1, r1c1, r0c2, r1c2), then SEND.
  - Expected: row1 lanes {2,4,6,0} at t+2, then row0 {1,3,5,0} at t+3; out_valid high exactly 2 cycles; dim_x=2, dim_y=3.
- Stalls: same 2x3 load with stop=1 on every other cycle -> identical stored tile and SEND output; LOAD lasts 12 cycles instead of 6.
- Clamp and ignore: LOAD dim_x_in=9, dim_y_in=7 -> dim_x=4, dim_y=4, accepts 16 elements. LOAD with dim_y_in=0 -> stays IDLE. SEND after reset -> no out_valid.
- Abort: during 4x4 LOAD after 5 elements, stop=1 with cmd=CLEAR -> CLEAR then IDLE; dims 0; a following 1x1 LOAD of A=-3 and SEND -> B1 lanes {-3,0,0,0}.
- Mid-send reset: assert rst during the second row of a 4-row SEND -> out_valid=0 next cycle, IDLE. A re-issued SEND with a reloaded tile streams correctly.

Source files
------------

// File: rtl/buffer_a_in.sv
// Input-side row buffer for the systolic MMU.
// Loads a tile column-major, one element per cycle; replays rows last-first.
module buffer_a_in #(
    parameter int VAR_SIZE = 8,
    parameter int MMU_SIZE = 4,
    parameter int DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [VAR_SIZE-1:0]          A,
    input  logic                         stop,
    input  logic [1:0]                   cmd,
    input  logic [7:0]                   dim_x_in,
    input  logic [7:0]                   dim_y_in,
    output logic [VAR_SIZE*MMU_SIZE-1:0] B1,
    output logic                         out_valid,
    output logic                         busy,
    output logic [7:0]                   dim_x,
    output logic [7:0]                   dim_y
);

    localparam int W  = VAR_SIZE * MMU_SIZE;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = (MMU_SIZE > 1) ? $clog2(MMU_SIZE) : 1;
    localparam logic [7:0] DEPTH_W = 8'(DEPTH);
    localparam logic [7:0] LANES_W = 8'(MMU_SIZE);

    localparam logic [1:0] CMD_LOAD  = 2'b01;
    localparam logic [1:0] CMD_SEND  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_CLEAR
    } state_t;

    state_t     state;
    logic [W-1:0] mem [DEPTH];
    logic [7:0] row_ptr;
    logic [7:0] col_ptr;
    logic [7:0] dx;
    logic [7:0] dy;
    logic       last_row;
    logic       last_el;
    logic       wr_en;
    logic [W-1:0] masked;
    logic [AW-1:0] ra;
    logic [LW-1:0] ca;

    assign ra = row_ptr[AW-1:0];
    assign ca = col_ptr[LW-1:0];
    assign busy = (state != S_IDLE);
    assign last_row = (row_ptr == dim_x - 8'd1);
    assign last_el = last_row && (col_ptr == dim_y - 8'd1);
    assign wr_en = (state == S_LOAD) && !stop && !rst;

    // Clamp requested tile dimensions to the physical buffer size
    always_comb begin
        dx = (dim_x_in > DEPTH_W) ? DEPTH_W : dim_x_in;
        dy = (dim_y_in > LANES_W) ? LANES_W : dim_y_in;
    end

    // Row being sent, with lanes beyond the tile width zeroed
    always_comb begin
        masked = mem[ra];
        for (int k = 0; k < MMU_SIZE; k++) begin
            if (8'(k) >= dim_y) masked[k*VAR_SIZE +: VAR_SIZE] = '0;
        end
    end

    // Storage: element writes during LOAD, bulk zero on CLEAR, kept across reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (wr_en) begin
                mem[ra][ca*VAR_SIZE +: VAR_SIZE] <= A;
            end
        end
    end

    // Control FSM with registered row output
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            row_ptr   <= '0;
            col_ptr   <= '0;
            dim_x     <= '0;
            dim_y     <= '0;
            B1        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (cmd == CMD_LOAD) begin
                        if (dx != 8'd0 && dy != 8'd0) begin
                            dim_x   <= dx;
                            dim_y   <= dy;
                            row_ptr <= '0;
                            col_ptr <= '0;
                            state   <= S_LOAD;
                        end
                    end else if (cmd == CMD_SEND) begin
                        if (dim_x != 8'd0) begin
                            row_ptr <= dim_x - 8'd1;
                            state   <= S_SEND;
                        end
                    end else if (cmd == CMD_CLEAR) begin
                        state <= S_CLEAR;
                    end
                end
                S_LOAD: begin
                    if (stop) begin
                        if (cmd == CMD_CLEAR) state <= S_CLEAR;
                    end else if (last_el) begin
                        row_ptr <= '0;
                        col_ptr <= '0;
                        state   <= S_IDLE;
                    end else if (last_row) begin
                        row_ptr <= '0;
                        col_ptr <= col_ptr + 8'd1;
                    end else begin
                        row_ptr <= row_ptr + 8'd1;
                    end
                end
                S_SEND: begin
                    B1        <= masked;
                    out_valid <= 1'b1;
                    if (row_ptr == 8'd0) begin
                        state <= S_IDLE;
                    end else begin
                        row_ptr <= row_ptr - 8'd1;
                    end
                end
                S_CLEAR: begin
                    dim_x   <= '0;
                    dim_y   <= '0;
                    row_ptr <= '0;
                    col_ptr <= '0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
